alu_seq_16: RTL and testbench
=============================

// Module: alu_seq_16
// PURPOSE
//  Parametrised, registered ALU: next generation of the lab ALU datapath. Ops: ADD/SUB/AND/OR/XOR
//  complete one cycle after accept; optional MUL runs as a multi-cycle shift-add.
//  Valid/ready on input and output. Sits between the operand register file and writeback.
// PARAMETERS
//  WIDTH    16  operand/result width in bits (>=4)
//  OPW      3   opcode width
// PORTS
//  Clk       in   1      rising-edge clock
//  Reset     in   1      synchronous, active-high reset
//  InValid   in   1      operands/op presented
//  InReady   out  1      block accepts operands (IDLE only)
//  Op        in   OPW    000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL
//  A         in   WIDTH  operand A (unsigned)
//  B         in   WIDTH  operand B (unsigned)
//  OutValid  out  1      result valid; held until OutReady
//  OutReady  in   1      consumer takes result
//  nBitOut   out  WIDTH  result
//  CB        out  1      ADD carry / SUB borrow / MUL high-half-nonzero; 0 for logic ops
//  Zero      out  1      nBitOut == 0
//  Err       out  1      illegal opcode; nBitOut=0, CB=0, Zero=1
// BEHAVIOUR
//  Reset: state IDLE; InReady=1 is the only output high; OutValid, nBitOut, CB, Zero, Err = 0.
//  Reset has priority in any state; an in-flight op is discarded, no result emitted.
//  FSM: IDLE --accept, op!=MUL--> DONE; IDLE --accept MUL--> BUSY; BUSY --count==WIDTH-1--> DONE;
//       DONE --OutReady--> IDLE.
//  Accept = InValid & InReady. InReady = (state==IDLE); no bypass DONE->accept in the same cycle.
//  Operands and op captured at accept; A/B/Op changes afterwards have no effect.
//  Single-cycle ops: OutValid rises on the cycle after accept (latency 1).
//  ADD: {CB,nBitOut} = A + B (WIDTH+1-bit sum).
//  SUB: nBitOut = A - B mod 2^WIDTH; CB = 1 iff A < B (borrow).
//  MUL: LSB-first shift-add over WIDTH cycles in BUSY; nBitOut = low WIDTH bits of A*B;
//       CB = |high WIDTH bits. OutValid rises WIDTH+1 cycles after accept.
//  Outputs are registered and stable while OutValid=1 & OutReady=0 (back-pressure any length).
//  OutValid drops the cycle after OutReady seen in DONE; InReady rises the same cycle.
//  InValid while busy is ignored (not queued); upstream must hold until InReady.
//  Codes 110/111 (and 101 when MUL compiled out): Err=1, latency 1, CB=0, nBitOut=0.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined: MUL op, BUSY state and multiplier sub-module present.
//  Not defined: no BUSY state, no multiplier logic; op 101 treated as illegal (Err=1).
// STRUCTURE
//  alu_seq_pkg: opcode localparams (OP_ADD..OP_MUL), FSM state encodings (IDLE/BUSY/DONE),
//    flag bit positions; shared with the decoder and bench.
//  Sub-module alu_seq_mul: start/done shift-add iterator, WIDTH-bit in, 2*WIDTH-bit product,
//    $clog2(WIDTH)-bit counter; instantiated only under ALU_SEQ_MUL_EN.
//  Top holds FSM, operand/result registers and single-cycle combinational ops.
// TESTING (WIDTH=16)
//  1 ADD 0xFFFF+0x0001, OutReady=1 -> next cycle OutValid=1, nBitOut=0x0000, CB=1, Zero=1.
//  2 SUB 0x0003-0x0005 -> nBitOut=0xFFFE, CB=1; SUB 0x0005-0x0003 -> 0x0002, CB=0.
//  3 XOR 0xA5A5^0x5A5A, OutReady=0 for 5 cycles -> 0xFFFF held, InReady=0 throughout,
//    OutValid drops the cycle after OutReady=1.
//  4 MUL 0x0100*0x0100 (MUL_EN) -> OutValid at accept+17, nBitOut=0x0000, CB=1;
//    MUL 0x00FF*0x0002 -> 0x01FE, CB=0; without MUL_EN -> Err=1 after 1 cycle.
//  5 Assert Reset mid-MUL (BUSY cycle 5) -> next cycle IDLE, InReady=1, OutValid=0, no result.
//  6 Op=111 with A=0x1234 -> Err=1, nBitOut=0, Zero=1; InValid during BUSY/DONE not accepted.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encodings and flag bit positions for the sequential ALU.
package alu_seq_pkg;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLAG_CB   = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_ERR  = 2;
    localparam int FLAG_W    = 3;
endpackage

// File: rtl/alu_seq_mul.sv
// LSB-first shift-add multiplier: one partial product per cycle, one-cycle done pulse
// in the cycle after the last iteration, with the full 2*WIDTH-bit product on o_prod.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;
    logic               r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_mcand  <= {{WIDTH{1'b0}}, i_a};
                r_mplier <= i_b;
                r_prod   <= '0;
                r_cnt    <= '0;
                r_run    <= 1'b1;
            end else if (r_run) begin
                if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_prod = r_prod;
endmodule

// File: rtl/alu_seq_16.sv
// Registered valid/ready ALU (ADD/SUB/AND/OR/XOR in one cycle); the multi-cycle MUL
// path, its BUSY state and the multiplier exist only when ALU_SEQ_MUL_EN is defined.
module alu_seq_16 #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [OPW-1:0]   Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] nBitOut,
    output logic             CB,
    output logic             Zero,
    output logic             Err
);
    import alu_seq_pkg::*;

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_res;
    logic [FLAG_W-1:0]   r_flags;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_dif;
    logic [WIDTH-1:0]    w_res;
    logic                w_cb;
    logic                w_err;
    logic                w_accept;

    assign InReady  = (r_state == ST_IDLE);
    assign OutValid = (r_state == ST_DONE);
    assign w_accept = InValid & InReady;

`ifdef ALU_SEQ_MUL_EN
    logic               w_mul;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_start (w_accept & w_mul),
        .i_a     (A),
        .i_b     (B),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );
`endif

    // Single-cycle ops decode straight from the ports; results land in r_res at accept.
    always_comb begin
        w_sum = {1'b0, A} + {1'b0, B};
        w_dif = {1'b0, A} - {1'b0, B};
        w_res = '0;
        w_cb  = 1'b0;
        w_err = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_mul = 1'b0;
`endif
        case (Op)
            OPW'(OP_ADD): begin w_res = w_sum[WIDTH-1:0]; w_cb = w_sum[WIDTH]; end
            OPW'(OP_SUB): begin w_res = w_dif[WIDTH-1:0]; w_cb = w_dif[WIDTH]; end
            OPW'(OP_AND): w_res = A & B;
            OPW'(OP_OR):  w_res = A | B;
            OPW'(OP_XOR): w_res = A ^ B;
`ifdef ALU_SEQ_MUL_EN
            OPW'(OP_MUL): w_mul = 1'b1;
`endif
            default:      w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef ALU_SEQ_MUL_EN
                if (InValid) w_next = w_mul ? ST_BUSY : ST_DONE;
`else
                if (InValid) w_next = ST_DONE;
`endif
            end
`ifdef ALU_SEQ_MUL_EN
            ST_BUSY: if (w_mul_done) w_next = ST_DONE;
`endif
            ST_DONE: if (OutReady) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Result registers only load on completion, so they hold through any back-pressure.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_res   <= '0;
            r_flags <= '0;
`ifdef ALU_SEQ_MUL_EN
        end else if (r_state == ST_BUSY && w_mul_done) begin
            r_res              <= w_prod[WIDTH-1:0];
            r_flags[FLAG_CB]   <= |w_prod[2*WIDTH-1:WIDTH];
            r_flags[FLAG_ZERO] <= (w_prod[WIDTH-1:0] == '0);
            r_flags[FLAG_ERR]  <= 1'b0;
        end else if (w_accept && !w_mul) begin
`else
        end else if (w_accept) begin
`endif
            r_res              <= w_res;
            r_flags[FLAG_CB]   <= w_cb;
            r_flags[FLAG_ZERO] <= (w_res == '0);
            r_flags[FLAG_ERR]  <= w_err;
        end
    end

    assign nBitOut = r_res;
    assign CB      = r_flags[FLAG_CB];
    assign Zero    = r_flags[FLAG_ZERO];
    assign Err     = r_flags[FLAG_ERR];
endmodule

// File: tb/tb_alu_seq_16.sv
// Directed bench for alu_seq_16 (WIDTH=16); MUL scenarios follow ALU_SEQ_MUL_EN.
module tb_alu_seq_16;
    import alu_seq_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [2:0]  Op = 3'b000;
    logic [15:0] A = 16'h0;
    logic [15:0] B = 16'h0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [15:0] nBitOut;
    logic        CB, Zero, Err;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    alu_seq_16 #(.WIDTH(16), .OPW(3)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady), .Op(Op),
        .A(A), .B(B), .OutValid(OutValid), .OutReady(OutReady), .nBitOut(nBitOut),
        .CB(CB), .Zero(Zero), .Err(Err)
    );

    task automatic step();
        @(posedge Clk); #1;
    endtask

    // Present one transaction and return #1 after its accept edge.
    task automatic do_accept(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        while (!InReady && n < 50) begin step(); n++; end
        checks++;
        if (InReady !== 1'b1) begin errors++; $display("FAIL accept_wait InReady=%b required 1", InReady); end
        Op = op; A = a; B = b; InValid = 1'b1;
        step();
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        step(); step();
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL rst_inready got %b exp 1", InReady); end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rst_outvalid got %b exp 0", OutValid); end
        checks++; if (nBitOut !== 16'h0) begin errors++; $display("FAIL rst_result got %h exp 0000", nBitOut); end
        checks++; if ({CB, Zero, Err} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {CB, Zero, Err}); end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_add();
        OutReady = 1'b1;
        do_accept(OP_ADD, 16'hFFFF, 16'h0001);
        checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", OutValid); end
        checks++; if (nBitOut !== 16'h0000) begin errors++; $display("FAIL add_result got %h exp 0000", nBitOut); end
        checks++; if ({CB, Zero, Err} !== 3'b110) begin errors++; $display("FAIL add_flags got %b exp 110", {CB, Zero, Err}); end
        step();
        checks++; if ({OutValid, InReady} !== 2'b01) begin errors++; $display("FAIL add_release got %b exp 01", {OutValid, InReady}); end
    endtask

    task automatic test_sub();
        OutReady = 1'b1;
        do_accept(OP_SUB, 16'h0003, 16'h0005);
        checks++; if ({OutValid, nBitOut} !== {1'b1, 16'hFFFE}) begin errors++; $display("FAIL sub_neg got %b/%h exp 1/fffe", OutValid, nBitOut); end
        checks++; if ({CB, Zero, Err} !== 3'b100) begin errors++; $display("FAIL sub_neg_flags got %b exp 100", {CB, Zero, Err}); end
        step();
        do_accept(OP_SUB, 16'h0005, 16'h0003);
        checks++; if (nBitOut !== 16'h0002) begin errors++; $display("FAIL sub_pos got %h exp 0002", nBitOut); end
        checks++; if ({CB, Zero, Err} !== 3'b000) begin errors++; $display("FAIL sub_pos_flags got %b exp 000", {CB, Zero, Err}); end
        step();
        do_accept(OP_AND, 16'hF0F0, 16'h3C3C);
        checks++; if (nBitOut !== 16'h3030) begin errors++; $display("FAIL and got %h exp 3030", nBitOut); end
        step();
        do_accept(OP_OR, 16'hF000, 16'h000F);
        checks++; if (nBitOut !== 16'hF00F) begin errors++; $display("FAIL or got %h exp f00f", nBitOut); end
        step();
    endtask

    task automatic test_backpressure();
        OutReady = 1'b0;
        do_accept(OP_XOR, 16'hA5A5, 16'h5A5A);
        Op = OP_ADD; A = 16'h0000; B = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({OutValid, InReady, nBitOut, CB} !== {1'b1, 1'b0, 16'hFFFF, 1'b0}) begin
                errors++; $display("FAIL xor_hold cyc %0d got v=%b r=%b %h cb=%b exp v=1 r=0 ffff cb=0", i, OutValid, InReady, nBitOut, CB);
            end
            step();
        end
        OutReady = 1'b1;
        step();
        checks++; if ({OutValid, InReady} !== 2'b01) begin errors++; $display("FAIL xor_drop got %b exp 01", {OutValid, InReady}); end
    endtask

    task automatic test_illegal();
        OutReady = 1'b0;
        do_accept(3'b111, 16'h1234, 16'h0000);
        checks++; if ({OutValid, nBitOut} !== {1'b1, 16'h0}) begin errors++; $display("FAIL ill7_result got %b/%h exp 1/0000", OutValid, nBitOut); end
        checks++; if ({CB, Zero, Err} !== 3'b011) begin errors++; $display("FAIL ill7_flags got %b exp 011", {CB, Zero, Err}); end
        Op = OP_ADD; A = 16'h0001; B = 16'h0001; InValid = 1'b1;
        step(); step();
        checks++; if ({InReady, Err, nBitOut} !== {1'b0, 1'b1, 16'h0}) begin errors++; $display("FAIL done_ignore got r=%b e=%b %h exp r=0 e=1 0000", InReady, Err, nBitOut); end
        InValid = 1'b0; OutReady = 1'b1;
        step();
        do_accept(3'b110, 16'hFFFF, 16'hFFFF);
        checks++; if ({Err, CB, nBitOut} !== {1'b1, 1'b0, 16'h0}) begin errors++; $display("FAIL ill6 got e=%b cb=%b %h exp e=1 cb=0 0000", Err, CB, nBitOut); end
        step();
    endtask

    task automatic test_back_to_back();
        OutReady = 1'b1;
        do_accept(OP_ADD, 16'h0001, 16'h0002);
        checks++; if (nBitOut !== 16'h0003) begin errors++; $display("FAIL b2b_first got %h exp 0003", nBitOut); end
        A = 16'h0005; B = 16'h0006; Op = OP_ADD; InValid = 1'b1;
        step();
        checks++; if ({OutValid, InReady} !== 2'b01) begin errors++; $display("FAIL b2b_gap got %b exp 01", {OutValid, InReady}); end
        step();
        InValid = 1'b0;
        checks++; if ({OutValid, nBitOut} !== {1'b1, 16'h000B}) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/000b", OutValid, nBitOut); end
        step();
    endtask

    task automatic test_mul();
`ifdef ALU_SEQ_MUL_EN
        int lat;
        OutReady = 1'b0;
        do_accept(OP_MUL, 16'h0100, 16'h0100);
        Op = OP_ADD; A = 16'h0001; B = 16'h0001; InValid = 1'b1;
        lat = 0;
        while (!OutValid && lat < 40) begin step(); lat++; end
        checks++; if (lat != 17) begin errors++; $display("FAIL mul_latency got %0d exp 17", lat); end
        checks++; if ({nBitOut, CB, Zero, Err} !== {16'h0000, 3'b110}) begin errors++; $display("FAIL mul_big got %h %b exp 0000 110", nBitOut, {CB, Zero, Err}); end
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL mul_inready got %b exp 0", InReady); end
        InValid = 1'b0; OutReady = 1'b1;
        step();
        do_accept(OP_MUL, 16'h00FF, 16'h0002);
        lat = 0;
        while (!OutValid && lat < 40) begin step(); lat++; end
        checks++; if ({nBitOut, CB, Zero, Err} !== {16'h01FE, 3'b000}) begin errors++; $display("FAIL mul_small got %h %b exp 01fe 000", nBitOut, {CB, Zero, Err}); end
        step();
`else
        OutReady = 1'b1;
        do_accept(OP_MUL, 16'h00FF, 16'h0002);
        checks++; if ({OutValid, Err, nBitOut} !== {1'b1, 1'b1, 16'h0}) begin errors++; $display("FAIL mul_off got v=%b e=%b %h exp v=1 e=1 0000", OutValid, Err, nBitOut); end
        step();
`endif
    endtask

    task automatic test_reset_midop();
        int seen = 0;
`ifdef ALU_SEQ_MUL_EN
        OutReady = 1'b1;
        do_accept(OP_MUL, 16'h0100, 16'h0100);
        step(); step(); step(); step();
`else
        OutReady = 1'b0;
        do_accept(OP_ADD, 16'h0001, 16'h0001);
`endif
        Reset = 1'b1;
        step();
        checks++; if ({InReady, OutValid, nBitOut} !== {1'b1, 1'b0, 16'h0}) begin errors++; $display("FAIL midrst got r=%b v=%b %h exp r=1 v=0 0000", InReady, OutValid, nBitOut); end
        Reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (OutValid) seen++;
            step();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_result got %0d valid cycles exp 0", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_mul();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
